dvp_frame_sched: RTL and testbench

DVP_FRAME_SCHED -- requirements
Module: dvp_frame_sched

---
 rtl/dvp_frame_sched.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_dvp_frame_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_frame_sched.sv
// -----------------------------------------------------------------------------
// dvp_frame_sched
//
// Frame-buffer scheduler for a DVP camera pipeline. A writer (camera side)
// and a reader (display/DMA side) share one, two or three frame buffers laid
// out at BASE + idx*STRIDE. The block rotates buffer indices on writer
// completion (wr_done) and reader start (rd_start) pulses, counts frames and
// dropped frames, and exposes a small register file on an APB-style bus.
//
// Ports
//   io_ahb_PCLK        clock for all logic
//   io_ahb_PRESET      asynchronous active-high reset
//   io_ahb_PADDR[2:0]  register word index
//   io_ahb_PSEL/PENABLE/PWRITE  bus access qualifiers
//   io_ahb_PWDATA[31:0] write data
//   io_ahb_PRDATA[31:0] read data (combinational, 0 outside a read access)
//   io_ahb_PREADY      always 1 (zero wait states)
//   io_ahb_PSLVERROR   always 0
//   wr_done            one-cycle pulse: writer finished a frame
//   rd_start           one-cycle pulse: reader starts a frame
//   wr_base[31:0]      registered writer frame base address
//   rd_base[31:0]      registered reader frame base address
//   frame_irq          one-cycle pulse after an accepted wr_done (IRQ_EN=1)
//
// Register map (word index)
//   0 CR     RW  [0] EN, [2:1] NBUF, [3] FREEZE, [4] IRQ_EN
//   1 SR     RO  [1:0] wr_idx, [3:2] rd_idx, [5:4] rdy_idx, [6] rdy_valid,
//                [31:16] drop_cnt
//   2 BASE   RW
//   3 STRIDE RW
//   4 WR_CNT RO
//   5 RD_CNT RO
//   6 CLR    WO  bit0=1 clears WR_CNT, RD_CNT and drop_cnt; reads 0
//   7 reserved, reads 0, writes ignored
// -----------------------------------------------------------------------------
module dvp_frame_sched #(
    parameter logic [31:0] DEF_BASE   = 32'h0000_0000,
    parameter logic [31:0] DEF_STRIDE = 32'h0038_4000
) (
    input  logic        io_ahb_PCLK,
    input  logic        io_ahb_PRESET,
    input  logic [2:0]  io_ahb_PADDR,
    input  logic        io_ahb_PSEL,
    input  logic        io_ahb_PENABLE,
    input  logic        io_ahb_PWRITE,
    input  logic [31:0] io_ahb_PWDATA,
    output logic [31:0] io_ahb_PRDATA,
    output logic        io_ahb_PREADY,
    output logic        io_ahb_PSLVERROR,
    input  logic        wr_done,
    input  logic        rd_start,
    output logic [31:0] wr_base,
    output logic [31:0] rd_base,
    output logic        frame_irq
);

    localparam logic [2:0] ADDR_CR     = 3'd0;
    localparam logic [2:0] ADDR_SR     = 3'd1;
    localparam logic [2:0] ADDR_BASE   = 3'd2;
    localparam logic [2:0] ADDR_STRIDE = 3'd3;
    localparam logic [2:0] ADDR_WRCNT  = 3'd4;
    localparam logic [2:0] ADDR_RDCNT  = 3'd5;
    localparam logic [2:0] ADDR_CLR    = 3'd6;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]  cr_reg,        cr_next;
    logic [31:0] base_reg,      base_next;
    logic [31:0] stride_reg,    stride_next;
    logic [31:0] wr_cnt_reg,    wr_cnt_next;
    logic [31:0] rd_cnt_reg,    rd_cnt_next;
    logic [15:0] drop_cnt_reg,  drop_cnt_next;
    logic [1:0]  wr_idx_reg,    wr_idx_next;
    logic [1:0]  rd_idx_reg,    rd_idx_next;
    logic [1:0]  rdy_idx_reg,   rdy_idx_next;
    logic        rdy_valid_reg, rdy_valid_next;
    logic        frame_irq_reg, frame_irq_next;

    // CR field views
    logic       cr_en;
    logic [1:0] cr_nbuf;
    logic       cr_freeze;
    logic       cr_irq_en;
    logic       single_buf;

    assign cr_en      = cr_reg[0];
    assign cr_nbuf    = cr_reg[2:1];
    assign cr_freeze  = cr_reg[3];
    assign cr_irq_en  = cr_reg[4];
    // NBUF 00 and 01 both mean a single buffer
    assign single_buf = ~cr_nbuf[1];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic bus_wr;
    logic bus_rd;
    logic cr_wr;
    logic reinit;
    logic clr;

    assign bus_wr = io_ahb_PSEL & io_ahb_PENABLE & io_ahb_PWRITE;
    assign bus_rd = io_ahb_PSEL & io_ahb_PENABLE & ~io_ahb_PWRITE;
    assign cr_wr  = bus_wr && (io_ahb_PADDR == ADDR_CR);
    // Changing EN or NBUF restarts the rotation from a known index set
    assign reinit = cr_wr && ((io_ahb_PWDATA[0]   != cr_en) ||
                              (io_ahb_PWDATA[2:1] != cr_nbuf));
    assign clr    = bus_wr && (io_ahb_PADDR == ADDR_CLR) && io_ahb_PWDATA[0];

    assign io_ahb_PREADY    = 1'b1;
    assign io_ahb_PSLVERROR = 1'b0;

    // Events that actually reach the scheduler this cycle
    logic wr_ev;
    logic rd_ev;

    assign wr_ev = cr_en && wr_done  && !reinit;
    assign rd_ev = cr_en && rd_start && !reinit;

    // Indices as seen by the outside world (single buffer pins both to 0)
    logic [1:0] wr_idx_eff;
    logic [1:0] rd_idx_eff;

    assign wr_idx_eff = single_buf ? 2'd0 : wr_idx_reg;
    assign rd_idx_eff = single_buf ? 2'd0 : rd_idx_reg;

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    always_comb begin
        cr_next     = cr_reg;
        base_next   = base_reg;
        stride_next = stride_reg;
        if (bus_wr) begin
            case (io_ahb_PADDR)
                ADDR_CR:     cr_next     = io_ahb_PWDATA[4:0];
                ADDR_BASE:   base_next   = io_ahb_PWDATA;
                ADDR_STRIDE: stride_next = io_ahb_PWDATA;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Buffer rotation and counters. A same-cycle wr_done is applied first
    // and rd_start then sees its result, so the rd_start path works on the
    // *_next values rather than the registered ones.
    // ------------------------------------------------------------------
    logic       drop_inc;
    logic [1:0] swap_tmp;

    always_comb begin
        wr_idx_next    = wr_idx_reg;
        rd_idx_next    = rd_idx_reg;
        rdy_idx_next   = rdy_idx_reg;
        rdy_valid_next = rdy_valid_reg;
        drop_inc       = 1'b0;
        swap_tmp       = 2'd0;

        if (reinit) begin
            wr_idx_next    = 2'd0;
            rd_idx_next    = 2'd1;
            rdy_idx_next   = 2'd2;
            rdy_valid_next = 1'b0;
        end else begin
            case (cr_nbuf)
                2'b10: begin
                    // Double: the finished frame stays in wr_idx until the
                    // reader takes it by swapping wr/rd.
                    if (wr_ev) begin
                        drop_inc       = rdy_valid_reg;
                        rdy_valid_next = 1'b1;
                    end
                    if (rd_ev && rdy_valid_next && !cr_freeze) begin
                        swap_tmp       = wr_idx_next;
                        wr_idx_next    = rd_idx_next;
                        rd_idx_next    = swap_tmp;
                        rdy_valid_next = 1'b0;
                    end
                end
                2'b11: begin
                    // Triple: finished frames park in rdy_idx
                    if (wr_ev) begin
                        wr_idx_next    = rdy_idx_reg;
                        rdy_idx_next   = wr_idx_reg;
                        drop_inc       = rdy_valid_reg;
                        rdy_valid_next = 1'b1;
                    end
                    if (rd_ev && rdy_valid_next && !cr_freeze) begin
                        swap_tmp       = rdy_idx_next;
                        rdy_idx_next   = rd_idx_next;
                        rd_idx_next    = swap_tmp;
                        rdy_valid_next = 1'b0;
                    end
                end
                default: begin
                    rdy_valid_next = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wr_cnt_next   = wr_cnt_reg + {31'd0, wr_ev};
        rd_cnt_next   = rd_cnt_reg + {31'd0, rd_ev};
        drop_cnt_next = drop_cnt_reg;
        if (drop_inc && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_next = drop_cnt_reg + 16'd1;
        end
        if (clr) begin
            wr_cnt_next   = 32'd0;
            rd_cnt_next   = 32'd0;
            drop_cnt_next = 16'd0;
        end
        frame_irq_next = wr_ev && cr_irq_en;
    end

    always_ff @(posedge io_ahb_PCLK or posedge io_ahb_PRESET) begin
        if (io_ahb_PRESET) begin
            cr_reg        <= 5'h07;
            base_reg      <= DEF_BASE;
            stride_reg    <= DEF_STRIDE;
            wr_cnt_reg    <= 32'd0;
            rd_cnt_reg    <= 32'd0;
            drop_cnt_reg  <= 16'd0;
            wr_idx_reg    <= 2'd0;
            rd_idx_reg    <= 2'd1;
            rdy_idx_reg   <= 2'd2;
            rdy_valid_reg <= 1'b0;
            frame_irq_reg <= 1'b0;
        end else begin
            cr_reg        <= cr_next;
            base_reg      <= base_next;
            stride_reg    <= stride_next;
            wr_cnt_reg    <= wr_cnt_next;
            rd_cnt_reg    <= rd_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
            wr_idx_reg    <= wr_idx_next;
            rd_idx_reg    <= rd_idx_next;
            rdy_idx_reg   <= rdy_idx_next;
            rdy_valid_reg <= rdy_valid_next;
            frame_irq_reg <= frame_irq_next;
        end
    end

    assign frame_irq = frame_irq_reg;

    // ------------------------------------------------------------------
    // Frame base addresses: BASE + idx*STRIDE, idx in 0..3, built from
    // shifted adds and wrapping modulo 2^32. Entry 0 is the writer,
    // entry 1 the reader.
    // ------------------------------------------------------------------
    logic [1:0] port_idx [2];

    assign port_idx[0] = wr_idx_eff;
    assign port_idx[1] = rd_idx_eff;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_base
            localparam logic [31:0] RST_ADDR = (gi == 0) ? DEF_BASE
                                                         : DEF_BASE + DEF_STRIDE;
            logic [31:0] offset;
            logic [31:0] addr_reg;

            always_comb begin
                offset = 32'd0;
                if (port_idx[gi][0]) offset = offset + stride_reg;
                if (port_idx[gi][1]) offset = offset + {stride_reg[30:0], 1'b0};
            end

            always_ff @(posedge io_ahb_PCLK or posedge io_ahb_PRESET) begin
                if (io_ahb_PRESET) begin
                    addr_reg <= RST_ADDR;
                end else begin
                    addr_reg <= base_reg + offset;
                end
            end
        end
    endgenerate

    assign wr_base = g_base[0].addr_reg;
    assign rd_base = g_base[1].addr_reg;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        io_ahb_PRDATA = 32'd0;
        if (bus_rd) begin
            case (io_ahb_PADDR)
                ADDR_CR:     io_ahb_PRDATA = {27'd0, cr_reg};
                ADDR_SR:     io_ahb_PRDATA = {drop_cnt_reg, 9'd0, rdy_valid_reg,
                                              rdy_idx_reg, rd_idx_eff, wr_idx_eff};
                ADDR_BASE:   io_ahb_PRDATA = base_reg;
                ADDR_STRIDE: io_ahb_PRDATA = stride_reg;
                ADDR_WRCNT:  io_ahb_PRDATA = wr_cnt_reg;
                ADDR_RDCNT:  io_ahb_PRDATA = rd_cnt_reg;
                default:     io_ahb_PRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_dvp_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_dvp_frame_sched
//
// Table of bus/pulse operations with hand-derived expected values. Register
// reads push their expected value into a queue when the read is driven; a
// negedge monitor pops and compares when the access phase presents PRDATA.
// Hand-written sequences cover frame_irq timing and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_dvp_frame_sched;

    localparam logic [31:0] DEF_BASE   = 32'h0000_0000;
    localparam logic [31:0] DEF_STRIDE = 32'h0038_4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  paddr = 3'd0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        wd = 1'b0;
    logic        rs = 1'b0;
    logic [31:0] wr_base;
    logic [31:0] rd_base;
    logic        frame_irq;

    always #5 clk = ~clk;

    dvp_frame_sched #(
        .DEF_BASE   (DEF_BASE),
        .DEF_STRIDE (DEF_STRIDE)
    ) dut (
        .io_ahb_PCLK      (clk),
        .io_ahb_PRESET    (rst),
        .io_ahb_PADDR     (paddr),
        .io_ahb_PSEL      (psel),
        .io_ahb_PENABLE   (penable),
        .io_ahb_PWRITE    (pwrite),
        .io_ahb_PWDATA    (pwdata),
        .io_ahb_PRDATA    (prdata),
        .io_ahb_PREADY    (pready),
        .io_ahb_PSLVERROR (pslverr),
        .wr_done          (wd),
        .rd_start         (rs),
        .wr_base          (wr_base),
        .rd_base          (rd_base),
        .frame_irq        (frame_irq)
    );

    typedef enum {OP_WR, OP_RD, OP_PULSE, OP_WB, OP_RB, OP_RST} op_t;

    typedef struct {
        op_t         op;
        logic [2:0]  addr;
        logic [31:0] data;
        logic        wd;
        logic        rs;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    vec_t    vecs[$];
    rd_exp_t rd_q[$];
    rd_exp_t mon_e;
    int      n_vec = 0;
    int      n_err = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endfunction

    function automatic void add(op_t op, logic [2:0] addr, logic [31:0] data,
                                logic w, logic r, logic [31:0] exp, string name);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data;
        v.wd = w;  v.rs = r;      v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] a, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.exp = exp; e.name = name;
        rd_q.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic pulse(input logic w, input logic r);
        @(posedge clk); #1;
        wd = w; rs = r;
        @(posedge clk); #1;
        wd = 1'b0; rs = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        psel = 1'b0; penable = 1'b0; wd = 1'b0; rs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: compares PRDATA during the access phase of a read
    always @(negedge clk) begin
        if (psel && penable && !pwrite) begin
            if (rd_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got %08h expected no read", prdata);
            end else begin
                mon_e = rd_q.pop_front();
                check(mon_e.name, prdata, mon_e.exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        add(OP_RD,    3'd0, 0, 0, 0, 32'h0000_0007, "rst_cr");
        add(OP_RD,    3'd1, 0, 0, 0, 32'h0000_0024, "rst_sr");
        add(OP_RD,    3'd2, 0, 0, 0, 32'h0000_0000, "rst_base");
        add(OP_RD,    3'd3, 0, 0, 0, 32'h0038_4000, "rst_stride");
        add(OP_RD,    3'd7, 0, 0, 0, 32'h0000_0000, "rst_reserved");
        add(OP_WB,    3'd0, 0, 0, 0, 32'h0000_0000, "rst_wr_base");
        add(OP_RB,    3'd0, 0, 0, 0, 32'h0038_4000, "rst_rd_base");
        // ---------------- triple-buffer sequencing ----------------
        add(OP_PULSE, 3'd0, 0, 1, 0, 0,             "");
        add(OP_WB,    3'd0, 0, 0, 0, 32'h0070_8000, "tri_wd_wr_base");
        add(OP_RD,    3'd1, 0, 0, 0, 32'h0000_0046, "tri_wd_sr");
        add(OP_PULSE, 3'd0, 0, 0, 1, 0,             "");
        add(OP_RB,    3'd0, 0, 0, 0, 32'h0000_0000, "tri_rs_rd_base");
        add(OP_RD,    3'd1, 0, 0, 0, 32'h0000_0012, "tri_rs_sr");
        // ---------------- drop counting and CLR ----------------
        add(OP_WR,    3'd6, 32'h1, 0, 0, 0,         "");
        add(OP_RD,    3'd4, 0, 0, 0, 32'h0000_0000, "clr_wr_cnt");
        add(OP_RD,    3'd5, 0, 0, 0, 32'h0000_0000, "clr_rd_cnt");
        add(OP_PULSE, 3'd0, 0, 1, 0, 0,             "");
        add(OP_PULSE, 3'd0, 0, 1, 0, 0,             "");
        add(OP_PULSE, 3'd0, 0, 1, 0, 0,             "");
        add(OP_RD,    3'd4, 0, 0, 0, 32'h0000_0003, "drop_wr_cnt");
        add(OP_RD,    3'd1, 0, 0, 0, 32'h0002_0061, "drop_sr");
        add(OP_WR,    3'd6, 32'h1, 0, 0, 0,         "");
        add(OP_RD,    3'd4, 0, 0, 0, 32'h0000_0000, "clr2_wr_cnt");
        add(OP_RD,    3'd1, 0, 0, 0, 32'h0000_0061, "clr2_sr");
        add(OP_RD,    3'd6, 0, 0, 0, 32'h0000_0000, "clr_reads0");
        // ---------------- simultaneous wr_done + rd_start ----------------
        add(OP_RST,   3'd0, 0, 0, 0, 0,             "");
        add(OP_PULSE, 3'd0, 0, 1, 0, 0,             "");
        add(OP_PULSE, 3'd0, 0, 1, 1, 0,             "");
        add(OP_RD,    3'd1, 0, 0, 0, 32'h0001_0018, "sim_sr");
        add(OP_RD,    3'd4, 0, 0, 0, 32'h0000_0002, "sim_wr_cnt");
        add(OP_RD,    3'd5, 0, 0, 0, 32'h0000_0001, "sim_rd_cnt");
        add(OP_WB,    3'd0, 0, 0, 0, 32'h0000_0000, "sim_wr_base");
        add(OP_RB,    3'd0, 0, 0, 0, 32'h0070_8000, "sim_rd_base");
        // ---------------- double buffer + FREEZE ----------------
        add(OP_WR,    3'd0, 32'h5, 0, 0, 0,         "");
        add(OP_RD,    3'd1, 0, 0, 0, 32'h0001_0024, "dbl_reinit_sr");
        add(OP_RD,    3'd0, 0, 0, 0, 32'h0000_0005, "dbl_cr");
        add(OP_PULSE, 3'd0, 0, 1, 0, 0,             "");
        add(OP_PULSE, 3'd0, 0, 0, 1, 0,             "");
        add(OP_RD,    3'd1, 0, 0, 0, 32'h0001_0021, "dbl_swap_sr");
        add(OP_WR,    3'd0, 32'hD, 0, 0, 0,         "");
        add(OP_PULSE, 3'd0, 0, 1, 0, 0,             "");
        add(OP_PULSE, 3'd0, 0, 0, 1, 0,             "");
        add(OP_RD,    3'd1, 0, 0, 0, 32'h0001_0061, "frz_sr");
        add(OP_RD,    3'd0, 0, 0, 0, 32'h0000_000D, "frz_cr");
        add(OP_WB,    3'd0, 0, 0, 0, 32'h0038_4000, "frz_wr_base");
        add(OP_RB,    3'd0, 0, 0, 0, 32'h0000_0000, "frz_rd_base");
        // ---------------- disable and address wrap ----------------
        add(OP_WR,    3'd6, 32'h1, 0, 0, 0,         "");
        add(OP_WR,    3'd0, 32'h6, 0, 0, 0,         "");
        add(OP_PULSE, 3'd0, 0, 1, 0, 0,             "");
        add(OP_PULSE, 3'd0, 0, 0, 1, 0,             "");
        add(OP_RD,    3'd4, 0, 0, 0, 32'h0000_0000, "dis_wr_cnt");
        add(OP_RD,    3'd5, 0, 0, 0, 32'h0000_0000, "dis_rd_cnt");
        add(OP_RD,    3'd1, 0, 0, 0, 32'h0000_0024, "dis_sr");
        add(OP_WR,    3'd0, 32'h7, 0, 0, 0,         "");
        add(OP_WR,    3'd2, 32'hFFFF_F000, 0, 0, 0, "");
        add(OP_WR,    3'd3, 32'h0000_2000, 0, 0, 0, "");
        add(OP_PULSE, 3'd0, 0, 1, 0, 0,             "");
        add(OP_WB,    3'd0, 0, 0, 0, 32'h0000_3000, "wrap_wr_base");
        add(OP_RB,    3'd0, 0, 0, 0, 32'h0000_1000, "wrap_rd_base");
        // ---------------- single buffer ----------------
        add(OP_WR,    3'd0, 32'h1, 0, 0, 0,         "");
        add(OP_PULSE, 3'd0, 0, 1, 0, 0,             "");
        add(OP_PULSE, 3'd0, 0, 0, 1, 0,             "");
        add(OP_RD,    3'd1, 0, 0, 0, 32'h0000_0020, "single_sr");
        add(OP_WB,    3'd0, 0, 0, 0, 32'hFFFF_F000, "single_wr_base");
        add(OP_RB,    3'd0, 0, 0, 0, 32'hFFFF_F000, "single_rd_base");
        add(OP_RD,    3'd4, 0, 0, 0, 32'h0000_0002, "single_wr_cnt");
        add(OP_RD,    3'd5, 0, 0, 0, 32'h0000_0001, "single_rd_cnt");
        // ---------------- reserved / masked bits ----------------
        add(OP_WR,    3'd7, 32'hFFFF_FFFF, 0, 0, 0, "");
        add(OP_RD,    3'd7, 0, 0, 0, 32'h0000_0000, "resv_reads0");
        add(OP_WR,    3'd0, 32'hFFFF_FFE1, 0, 0, 0, "");
        add(OP_RD,    3'd0, 0, 0, 0, 32'h0000_0001, "cr_mask");

        do_reset();
        check("pready", {31'd0, pready}, 32'd1);
        check("pslverr", {31'd0, pslverr}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_WR:    apb_write(vecs[i].addr, vecs[i].data);
                OP_RD:    apb_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
                OP_PULSE: pulse(vecs[i].wd, vecs[i].rs);
                OP_WB: begin
                    @(posedge clk); #1;
                    check(vecs[i].name, wr_base, vecs[i].exp);
                end
                OP_RB: begin
                    @(posedge clk); #1;
                    check(vecs[i].name, rd_base, vecs[i].exp);
                end
                OP_RST:   do_reset();
                default: ;
            endcase
        end

        // ---------------- frame_irq timing ----------------
        do_reset();
        apb_write(3'd0, 32'h17);
        pulse(1'b1, 1'b0);
        check("irq_high", {31'd0, frame_irq}, 32'd1);
        @(posedge clk); #1;
        check("irq_one_cycle", {31'd0, frame_irq}, 32'd0);
        apb_write(3'd0, 32'h07);
        pulse(1'b1, 1'b0);
        check("irq_disabled", {31'd0, frame_irq}, 32'd0);
        apb_write(3'd0, 32'h16);
        pulse(1'b1, 1'b0);
        check("irq_en0_ignored", {31'd0, frame_irq}, 32'd0);

        // ---------------- asynchronous reset ----------------
        do_reset();
        pulse(1'b1, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_wr_base", wr_base, 32'h0070_8000);
        @(negedge clk); #1;
        rst = 1'b1;
        wd  = 1'b1;
        #1;
        check("async_wr_base", wr_base, DEF_BASE);
        check("async_rd_base", rd_base, DEF_BASE + DEF_STRIDE);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wd  = 1'b0;
        apb_read(3'd1, 32'h0000_0024, "async_sr");
        apb_read(3'd0, 32'h0000_0007, "async_cr");
        apb_read(3'd4, 32'h0000_0000, "async_wr_cnt");

        // Any unserved read expectation is a miscompare
        @(posedge clk); #1;
        check("rd_q_drained", rd_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
